vga_pattern_gen: RTL and testbench

- 640x480@60 VGA timing generator and test-pattern source, clocked by the divided pixel clock (25 MHz).
- Sits directly upstream of the top-level pixel register stage and feeds it sync, display-area and per-channel colour bits.
- Debounces the colour-cycle (`sw_cc`) and pattern-cycle (`sw_cp`) buttons and applies the `sw_p1..3` channel masks.
- Pattern and colour changes take effect only at frame boundaries.

---
 rtl/vga_pattern_gen_if.sv | 28 ++
 rtl/vga_pattern_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen_if
// Brief    : Video output bundle (syncs, position, colour, frame marker).
// Revision : 1.0
// ============================================================================
interface vga_pattern_gen_if;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       inDisplayArea;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic       red;
  logic       green;
  logic       blue;
  logic       frame_start;

  modport master (
    output vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY,
           red, green, blue, frame_start
  );

  modport slave (
    input  vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY,
           red, green, blue, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : 640x480@60 VGA timing plus debounced test-pattern source.
//            Optional macro VGA_PATTERN_BORDER_EN adds a 1-pixel white border.
// Revision : 1.0
// ============================================================================
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int DEB_CYCLES = 250000
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          sw_cc,
  input  wire logic          sw_cp,
  input  wire logic          sw_p1,
  input  wire logic          sw_p2,
  input  wire logic          sw_p3,
  vga_pattern_gen_if.master  vga
);

  localparam int H_T   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_T   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  localparam logic [9:0] c_H_LAST   = 10'(H_T - 1);
  localparam logic [9:0] c_V_LAST   = 10'(V_T - 1);
  localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Button debounce: index 0 = colour cycle, index 1 = pattern cycle.
  logic [1:0] w_btn;
  logic [1:0] w_press;
  assign w_btn = {sw_cp, sw_cc};

  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic             sync1_q, sync2_q, stable_q, ev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q  <= 1'b1;
        sync2_q  <= 1'b1;
        stable_q <= 1'b1;
        ev_q     <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q <= w_btn[i];
        sync2_q <= sync1_q;
        ev_q    <= 1'b0;
        // Any return to the accepted level restarts the stability count.
        if (sync2_q == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
          cnt_q    <= '0;
          stable_q <= sync2_q;
          ev_q     <= ~sync2_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_press[i] = ev_q;
  end

  logic       first_q;
  logic [9:0] x_q, y_q, x_d, y_d;
  logic [2:0] pend_c_q, pend_c_d, act_c_q, act_c_d;
  logic [1:0] pend_p_q, pend_p_d, act_p_q, act_p_d;
  logic       hs_q, vs_q, de_q, fs_q, r_q, g_q, b_q;
  logic       hs_d, vs_d, de_d, fs_d;
  logic [2:0] rgb_d;

  // Position advance; the first cycle after reset holds at the origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!first_q) begin
      if (x_q == c_H_LAST) begin
        x_d = '0;
        y_d = (y_q == c_V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_comb begin
    fs_d     = (x_d == 10'd0) && (y_d == 10'd0);
    act_c_d  = fs_d ? pend_c_q : act_c_q;
    act_p_d  = fs_d ? pend_p_q : act_p_q;
    pend_c_d = pend_c_q + {2'b00, w_press[0]};
    pend_p_d = pend_p_q + {1'b0, w_press[1]};
    hs_d     = !((x_d >= c_HS_START) && (x_d < c_HS_END));
    vs_d     = !((y_d >= c_VS_START) && (y_d < c_VS_END));
    de_d     = (x_d < c_H_ACT) && (y_d < c_V_ACT);
    case (act_p_d)
      2'd0:    rgb_d = act_c_d;
      2'd1:    rgb_d = x_d[9:7] ^ act_c_d;
      2'd2:    rgb_d = y_d[8:6] ^ act_c_d;
      default: rgb_d = (x_d[5] ^ y_d[5]) ? act_c_d : ~act_c_d;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (de_d && ((x_d == 10'd0) || (x_d == c_H_ACT - 10'd1) ||
                 (y_d == 10'd0) || (y_d == c_V_ACT - 10'd1)))
      rgb_d = 3'b111;
`endif
    if (!de_d)
      rgb_d = 3'b000;
    rgb_d = rgb_d & {sw_p1, sw_p2, sw_p3};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q  <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      pend_c_q <= 3'd7;
      act_c_q  <= 3'd7;
      pend_p_q <= 2'd0;
      act_p_q  <= 2'd0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      r_q      <= 1'b0;
      g_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      first_q  <= 1'b0;
      x_q      <= x_d;
      y_q      <= y_d;
      pend_c_q <= pend_c_d;
      act_c_q  <= act_c_d;
      pend_p_q <= pend_p_d;
      act_p_q  <= act_p_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      r_q      <= rgb_d[2];
      g_q      <= rgb_d[1];
      b_q      <= rgb_d[0];
    end
  end

  assign vga.vga_h_sync    = hs_q;
  assign vga.vga_v_sync    = vs_q;
  assign vga.inDisplayArea = de_q;
  assign vga.CounterX      = x_q;
  assign vga.CounterY      = y_q;
  assign vga.red           = r_q;
  assign vga.green         = g_q;
  assign vga.blue          = b_q;
  assign vga.frame_start   = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_gen
// Brief    : Self-checking bench for vga_pattern_gen on a reduced raster.
// Revision : 1.0
// ============================================================================
module tb_vga_pattern_gen;

  localparam int HA = 132, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 66,  VFP = 2, VS = 2, VBP = 2;
  localparam int DEB = 40;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_cc = 1'b1, sw_cp = 1'b1;
  logic sw_p1 = 1'b1, sw_p2 = 1'b1, sw_p3 = 1'b1;

  vga_pattern_gen_if vif ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset),
    .sw_cc(sw_cc), .sw_cp(sw_cp),
    .sw_p1(sw_p1), .sw_p2(sw_p2), .sw_p3(sw_p3),
    .vga(vif)
  );

  always #5 clk = ~clk;

  int  n_pass = 0, n_tot = 0;
  int  cyc = 0, last_fs = -1;
  int  mx = 0, my = 0, m_pc = 7, m_pp = 0, m_ac = 7, m_ap = 0;
  bit  mfirst = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s x=%0d y=%0d observed=%h expected=%h", tag, mx, my, obs, exp);
  endtask

  // Expected output word {hs, vs, de, x, y, r, g, b, fs} from raster arithmetic.
  function automatic logic [31:0] model_out(int x, int y, int c, int p, bit fs);
    bit       hs, vs, de;
    int       rgb;
    hs = !(x >= HA + HFP && x < HA + HFP + HS);
    vs = !(y >= VA + VFP && y < VA + VFP + VS);
    de = (x < HA) && (y < VA);
    case (p)
      0:       rgb = c;
      1:       rgb = ((x / 128) % 8) ^ c;
      2:       rgb = ((y / 64) % 8) ^ c;
      default: rgb = (((x / 32) % 2) != ((y / 32) % 2)) ? c : 7 - c;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (de && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1)) rgb = 7;
`endif
    if (!de) rgb = 0;
    rgb = rgb & {29'd0, sw_p1, sw_p2, sw_p3};
    return {5'd0, hs, vs, de, 10'(x), 10'(y), 3'(rgb), fs};
  endfunction

  task automatic step();
    logic [31:0] exp, obs;
    bit fs;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      mfirst = 1'b1; mx = 0; my = 0;
      m_pc = 7; m_pp = 0; m_ac = 7; m_ap = 0;
      last_fs = -1;
      exp = {5'd0, 1'b1, 1'b1, 1'b0, 20'd0, 3'd0, 1'b0};
    end else begin
      if (mfirst) begin
        mfirst = 1'b0;
      end else begin
        mx++;
        if (mx == HT) begin
          mx = 0;
          my = (my + 1) % VT;
        end
      end
      fs = (mx == 0) && (my == 0);
      if (fs) begin
        m_ac = m_pc;
        m_ap = m_pp;
      end
      exp = model_out(mx, my, m_ac, m_ap, fs);
    end
    obs = {5'd0, vif.vga_h_sync, vif.vga_v_sync, vif.inDisplayArea,
           vif.CounterX, vif.CounterY, vif.red, vif.green, vif.blue,
           vif.frame_start};
    check("pixel", obs, exp);
    if (vif.frame_start === 1'b1) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(HT * VT));
      last_fs = cyc;
    end
  endtask

  task automatic run_to(input int tx, input int ty);
    int n = 0;
    while (!(mx == tx && my == ty) && n < HT * VT + 4) begin
      step();
      n++;
    end
    if (n >= HT * VT + 4) begin
      n_tot++;
      $display("FAIL run_to bound expired target=(%0d,%0d) reached=(%0d,%0d)", tx, ty, mx, my);
    end
  endtask

  task automatic next_frame();
    step();
    run_to(0, 0);
  endtask

  // Press one or both buttons, optionally with contact bounce first.
  task automatic press(input bit cc, input bit cp, input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        if (cc) sw_cc = ~sw_cc;
        if (cp) sw_cp = ~sw_cp;
        repeat (10) step();
      end
    end
    if (cc) sw_cc = 1'b0;
    if (cp) sw_cp = 1'b0;
    repeat (DEB + 10) step();
    if (cc) m_pc = (m_pc + 1) % 8;
    if (cp) m_pp = (m_pp + 1) % 4;
    sw_cc = 1'b1;
    sw_cp = 1'b1;
    repeat (DEB + 10) step();
  endtask

  initial begin
    // Reset state, then first frame with full enables.
    repeat (4) step();
    reset = 1'b0;
    run_to(0, 20);

    // Colour 7 -> 0 wrap mid-frame, then a bounced pattern press.
    press(1'b1, 1'b0, 1'b0);
    run_to(0, 30);
    press(1'b0, 1'b1, 1'b1);
    next_frame();

    // Randomised enables and presses, one decision set per frame.
    for (int f = 0; f < 2; f++) begin
      {sw_p1, sw_p2, sw_p3} = 3'($urandom_range(0, 7));
      run_to(0, $urandom_range(5, 25));
      repeat ($urandom_range(0, 2)) press(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      press(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      next_frame();
    end

    // Mid-frame reset discards a pending press and restarts the raster.
    {sw_p1, sw_p2, sw_p3} = 3'b111;
    run_to(0, 10);
    press(1'b1, 1'b1, 1'b0);
    run_to($urandom_range(0, HT - 1), $urandom_range(40, 60));
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    run_to(40, 40);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
